// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory access controller feeding the load unit
// One load/store at a time over a req/ack bus, with store-lane alignment and an ack timeout.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_req_in,
    input  logic        mem_wr_in,
    input  logic [1:0]  mem_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [3:0]  dm_wr_mask_o,
    output logic        dm_rd_req_o,
    output logic        dm_wr_req_o,
    input  logic        dm_ack_in,
    input  logic [31:0] dm_rdata_in,
    output logic [31:0] dm_data_o,
    output logic [1:0]  iadder_out_1to0_o,
    output logic        load_valid_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_WWAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;
    logic              r_rd_req;
    logic              r_wr_req;
    logic [31:0]       r_data;
    logic [1:0]        r_data_lo;
    logic              r_load_valid;
    logic              r_stall;
    logic              r_misaligned;
    logic              r_bus_err;

    logic [1:0]        w_k;
    logic              w_misaligned;
    logic [31:0]       w_wdata;
    logic [3:0]        w_mask;

    assign w_k = iadder_in[1:0];
    assign w_misaligned = (mem_size_in == 2'b01 && w_k[0]) ||
                          (mem_size_in[1] && w_k != 2'b00);

    // Replicate the store data across all lanes; the mask selects which bytes land.
    always_comb begin
        w_wdata = rs2_in;
        w_mask  = 4'b1111;
        case (mem_size_in)
            2'b00: begin
                w_wdata = {4{rs2_in[7:0]}};
                w_mask  = 4'b0001 << w_k;
            end
            2'b01: begin
                w_wdata = {2{rs2_in[15:0]}};
                w_mask  = w_k[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = rs2_in;
                w_mask  = 4'b1111;
            end
        endcase
        if (!mem_wr_in) begin
            w_wdata = 32'h0;
            w_mask  = 4'b0000;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= 32'h0;
            r_addr_lo    <= 2'b00;
            r_wdata      <= 32'h0;
            r_mask       <= 4'b0000;
            r_rd_req     <= 1'b0;
            r_wr_req     <= 1'b0;
            r_data       <= 32'h0;
            r_data_lo    <= 2'b00;
            r_load_valid <= 1'b0;
            r_stall      <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_in) begin
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_addr    <= {iadder_in[31:2], 2'b00};
                            r_addr_lo <= w_k;
                            r_wdata   <= w_wdata;
                            r_mask    <= w_mask;
                            r_rd_req  <= ~mem_wr_in;
                            r_wr_req  <= mem_wr_in;
                            r_stall   <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= mem_wr_in ? S_WWAIT : S_RWAIT;
                        end
                    end
                end
                S_RWAIT, S_WWAIT: begin
                    if (dm_ack_in) begin
                        if (r_state == S_RWAIT) begin
                            r_data       <= dm_rdata_in;
                            r_data_lo    <= r_addr_lo;
                            r_load_valid <= 1'b1;
                        end
                        r_rd_req <= 1'b0;
                        r_wr_req <= 1'b0;
                        r_stall  <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rd_req  <= 1'b0;
                        r_wr_req  <= 1'b0;
                        r_stall   <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dm_addr_o         = r_addr;
    assign dm_wdata_o        = r_wdata;
    assign dm_wr_mask_o      = r_mask;
    assign dm_rd_req_o       = r_rd_req;
    assign dm_wr_req_o       = r_wr_req;
    assign dm_data_o         = r_data;
    assign iadder_out_1to0_o = r_data_lo;
    assign load_valid_o      = r_load_valid;
    assign stall_o           = r_stall;
    assign misaligned_o      = r_misaligned;
    assign bus_err_o         = r_bus_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] iadder = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] dm_addr, dm_wdata, dm_data;
    logic [3:0]  dm_mask;
    logic [1:0]  lo;
    logic        rd_req, wr_req, load_valid, stall, misaligned, bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_stall = 0;
    int n_lv = 0;
    int snap_stall, snap_lv;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_in(clk), .rst_in(rst),
        .mem_req_in(mem_req), .mem_wr_in(mem_wr), .mem_size_in(mem_size),
        .iadder_in(iadder), .rs2_in(rs2),
        .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_wr_mask_o(dm_mask),
        .dm_rd_req_o(rd_req), .dm_wr_req_o(wr_req),
        .dm_ack_in(ack), .dm_rdata_in(rdata),
        .dm_data_o(dm_data), .iadder_out_1to0_o(lo),
        .load_valid_o(load_valid), .stall_o(stall),
        .misaligned_o(misaligned), .bus_err_o(bus_err)
    );

    always @(negedge clk) begin
        if (stall) n_stall <= n_stall + 1;
        if (load_valid) n_lv <= n_lv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
        mem_req = 1'b1; mem_wr = wr; mem_size = size; iadder = addr; rs2 = data;
        tick();
        mem_req = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
    } st_vec_t;

    st_vec_t st_tab[5] = '{
        '{2'b00, 32'h0000_0103, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000},
        '{2'b01, 32'h0000_0102, 32'h0000_1234, 32'h1234_1234, 4'b1100},
        '{2'b00, 32'h0000_0101, 32'hFFFF_FF3C, 32'h3C3C_3C3C, 4'b0010},
        '{2'b01, 32'h0000_0200, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b0011},
        '{2'b10, 32'h0000_0204, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'b1111}
    };

    initial begin
        tick();
        tick();
        chk("rst_addr", dm_addr, 32'h0);
        chk("rst_req", {30'h0, rd_req, wr_req}, 32'h0);
        chk("rst_flags", {28'h0, stall, load_valid, misaligned, bus_err}, 32'h0);
        chk("rst_data", dm_data, 32'h0);
        rst = 1'b0;
        tick();

        // Load word with ack on the second request cycle.
        snap_stall = n_stall; snap_lv = n_lv;
        issue(1'b0, 2'b10, 32'h0000_0100, 32'h0);
        chk("t1_rdreq", {31'h0, rd_req}, 32'h1);
        chk("t1_addr", dm_addr, 32'h0000_0100);
        chk("t1_mask", {28'h0, dm_mask}, 32'h0);
        chk("t1_stall", {31'h0, stall}, 32'h1);
        tick();
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; rdata = 32'h0;
        chk("t1_rdreq_drop", {31'h0, rd_req}, 32'h0);
        chk("t1_data", dm_data, 32'hDEAD_BEEF);
        chk("t1_lo", {30'h0, lo}, 32'h0);
        chk("t1_lv", {31'h0, load_valid}, 32'h1);
        tick();
        chk("t1_lv_end", {31'h0, load_valid}, 32'h0);
        chk("t1_stall_cnt", n_stall - snap_stall, 32'd2);
        chk("t1_lv_cnt", n_lv - snap_lv, 32'd1);

        // Stores through the alignment table, ack on the first request cycle.
        for (int i = 0; i < 5; i++) begin
            snap_lv = n_lv;
            issue(1'b1, st_tab[i].size, st_tab[i].addr, st_tab[i].data);
            chk($sformatf("st%0d_wrreq", i), {30'h0, rd_req, wr_req}, 32'h1);
            chk($sformatf("st%0d_wdata", i), dm_wdata, st_tab[i].exp_wdata);
            chk($sformatf("st%0d_mask", i), {28'h0, dm_mask}, {28'h0, st_tab[i].exp_mask});
            chk($sformatf("st%0d_addr", i), dm_addr, st_tab[i].addr & 32'hFFFF_FFFC);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk($sformatf("st%0d_wrdrop", i), {31'h0, wr_req}, 32'h0);
            tick();
            chk($sformatf("st%0d_nolv", i), n_lv - snap_lv, 32'd0);
        end

        // Misaligned half load.
        issue(1'b0, 2'b01, 32'h0000_0101, 32'h0);
        chk("t4_mis", {31'h0, misaligned}, 32'h1);
        chk("t4_req", {30'h0, rd_req, wr_req}, 32'h0);
        chk("t4_stall", {31'h0, stall}, 32'h0);
        tick();
        chk("t4_mis_end", {31'h0, misaligned}, 32'h0);
        chk("t4_data", dm_data, 32'hDEAD_BEEF);

        // Timeout: no ack for 16 wait cycles.
        snap_stall = n_stall; snap_lv = n_lv;
        issue(1'b0, 2'b10, 32'h0000_0300, 32'h0);
        for (int i = 1; i < 16; i++) tick();
        chk("t5_req_last", {31'h0, rd_req}, 32'h1);
        tick();
        chk("t5_req_drop", {31'h0, rd_req}, 32'h0);
        chk("t5_err", {31'h0, bus_err}, 32'h1);
        chk("t5_data", dm_data, 32'hDEAD_BEEF);
        tick();
        chk("t5_err_end", {31'h0, bus_err}, 32'h0);
        chk("t5_stall_cnt", n_stall - snap_stall, 32'd16);
        chk("t5_lv_cnt", n_lv - snap_lv, 32'd0);

        // Reset during RWAIT, late ack, then a normal byte load.
        issue(1'b0, 2'b10, 32'h0000_0400, 32'h0);
        chk("t6_rdreq", {31'h0, rd_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", {30'h0, rd_req, wr_req}, 32'h0);
        chk("t6_rst_stall", {31'h0, stall}, 32'h0);
        chk("t6_rst_addr", dm_addr, 32'h0);
        tick();
        ack = 1'b1; rdata = 32'h1111_1111;
        tick();
        rst = 1'b0;
        tick();
        ack = 1'b0;
        chk("t6_late_data", dm_data, 32'h0);
        chk("t6_late_lv", {31'h0, load_valid}, 32'h0);
        issue(1'b0, 2'b00, 32'h0000_0503, 32'h0);
        chk("t6_addr", dm_addr, 32'h0000_0500);
        ack = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        chk("t6_data", dm_data, 32'hCAFE_F00D);
        chk("t6_lo", {30'h0, lo}, 32'h3);
        chk("t6_lv", {31'h0, load_valid}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
